// File: rtl/unit_pkg.sv
// Shared encodings for the unit pool: slot lifecycle states, unit type codes
// and the per-type base attack power.
package unit_pkg;

  typedef enum logic [1:0] {
    StDead   = 2'd0,
    StDeploy = 2'd1,
    StAlive  = 2'd2,
    StDying  = 2'd3
  } slot_state_e;

  typedef enum logic [1:0] {
    TypeNone   = 2'd0,
    TypeLight  = 2'd1,
    TypeMedium = 2'd2,
    TypeHeavy  = 2'd3
  } unit_type_e;

  localparam int unsigned BasePowerW = 8;

  // Power at HP_W = 8; wider health widths shift this left by HP_W - 8.
  function automatic logic [BasePowerW-1:0] base_power(input logic [1:0] utype);
    logic [BasePowerW-1:0] p;
    case (utype)
      TypeLight:  p = 8'd32;
      TypeMedium: p = 8'd64;
      TypeHeavy:  p = 8'd128;
      default:    p = 8'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/unit_slot.sv
// One unit slot: DEAD -> DEPLOY -> ALIVE -> DYING -> DEAD lifecycle with
// position, health and attack power.
module unit_slot
  import unit_pkg::*;
#(
  parameter int unsigned POS_W      = 9,
  parameter int unsigned HP_W       = 8,
  parameter int unsigned DEATH_HOLD = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spawn_i,
  input  logic [1:0]        spawn_type_i,
  input  logic              hit_i,
  input  logic [HP_W-1:0]   hit_amount_i,
  input  logic              move_i,
  input  logic [POS_W-1:0]  enemy_front_i,
  output slot_state_e       state_o,
  output logic [POS_W-1:0]  position_o,
  output logic [1:0]        unit_type_o,
  output logic [HP_W-1:0]   power_o,
  output logic              attack_o
);

  localparam int unsigned HoldW = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;

  slot_state_e      state_q;
  logic [POS_W-1:0] position_q;
  logic [HP_W-1:0]  health_q;
  logic [HP_W-1:0]  power_q;
  logic [1:0]       type_q;
  logic [HoldW-1:0] hold_q;

  logic kill;
  logic ahead;

  assign kill  = (state_q == StAlive) && hit_i && (health_q <= hit_amount_i);
  assign ahead = position_q > enemy_front_i;
  // A slot killed on the tick edge neither moves nor attacks.
  assign attack_o = (state_q == StAlive) && move_i && !kill && !ahead;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StDead;
      position_q <= '1;
      health_q   <= '0;
      power_q    <= '0;
      type_q     <= TypeNone;
      hold_q     <= '0;
    end else begin
      case (state_q)
        StDead: begin
          if (spawn_i) begin
            state_q    <= StDeploy;
            position_q <= '1;
            health_q   <= '1;
            power_q    <= HP_W'(base_power(spawn_type_i)) << (HP_W - 8);
            type_q     <= spawn_type_i;
          end
        end
        StDeploy: state_q <= StAlive;
        StAlive: begin
          if (kill) begin
            state_q  <= StDying;
            health_q <= '0;
            hold_q   <= HoldW'(DEATH_HOLD - 1);
          end else begin
            if (hit_i) health_q <= health_q - hit_amount_i;
            // ahead implies position > 0, so this never wraps.
            if (move_i && ahead) position_q <= position_q - POS_W'(1);
          end
        end
        StDying: begin
          if (hold_q == '0) state_q <= StDead;
          else              hold_q  <= hold_q - HoldW'(1);
        end
        default: state_q <= StDead;
      endcase
    end
  end

  assign state_o     = state_q;
  assign position_o  = position_q;
  assign unit_type_o = (state_q == StAlive) ? type_q : 2'b00;
  assign power_o     = power_q;

endmodule

// File: rtl/unit_pool.sv
// Pool of unit slots: spawn arbitration with cooldown, per-tick attack
// summation and front-position reduction over living units.
module unit_pool
  import unit_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned POS_W      = 9,
  parameter int unsigned HP_W       = 8,
  parameter int unsigned COOLDOWN   = 15,
  parameter int unsigned DEATH_HOLD = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spawnSCEN,
  input  logic [1:0]                   spawnType,
  input  logic                         canSpawn,
  input  logic                         moveSCEN,
  input  logic                         damageSCEN,
  input  logic [$clog2(NUM_UNITS)-1:0] damageIdx,
  input  logic [HP_W-1:0]              damageIn,
  input  logic [POS_W-1:0]             enemyFront,
  output logic                         spawnAccept,
  output logic                         poolFull,
  output logic [NUM_UNITS*POS_W-1:0]   positionFlat,
  output logic [NUM_UNITS*2-1:0]       unitTypeFlat,
  output logic [NUM_UNITS-1:0]         aliveMask,
  output logic [HP_W-1:0]              damageOut,
  output logic [POS_W-1:0]             frontPos,
  output logic                         frontValid
);

  localparam int unsigned IdxW = $clog2(NUM_UNITS);
  localparam int unsigned CdW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  // Eight slots of all-ones power sum to less than 2^(HP_W+3).
  localparam int unsigned SumW = HP_W + 3;

  slot_state_e          slot_state [NUM_UNITS];
  logic [POS_W-1:0]     slot_pos   [NUM_UNITS];
  logic [HP_W-1:0]      slot_power [NUM_UNITS];
  logic [NUM_UNITS-1:0] attack;
  logic [NUM_UNITS-1:0] dead_mask;
  logic [NUM_UNITS-1:0] first_dead;
  logic [NUM_UNITS-1:0] spawn_sel;

  logic [CdW-1:0]  cooldown_q;
  logic            spawn_accept_q;
  logic [HP_W-1:0] damage_q;
  logic            accept;
  logic [SumW-1:0] attack_sum;
  logic [HP_W-1:0] attack_sat;
  logic [POS_W-1:0] front;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    logic hit;
    assign hit = damageSCEN && (damageIdx == IdxW'(g));

    unit_slot #(
      .POS_W      (POS_W),
      .HP_W       (HP_W),
      .DEATH_HOLD (DEATH_HOLD)
    ) u_slot (
      .clk           (clk),
      .reset         (reset),
      .spawn_i       (spawn_sel[g]),
      .spawn_type_i  (spawnType),
      .hit_i         (hit),
      .hit_amount_i  (damageIn),
      .move_i        (moveSCEN),
      .enemy_front_i (enemyFront),
      .state_o       (slot_state[g]),
      .position_o    (slot_pos[g]),
      .unit_type_o   (unitTypeFlat[g*2 +: 2]),
      .power_o       (slot_power[g]),
      .attack_o      (attack[g])
    );

    assign dead_mask[g]                  = (slot_state[g] == StDead);
    assign aliveMask[g]                  = (slot_state[g] == StAlive);
    assign positionFlat[g*POS_W +: POS_W] = slot_pos[g];
  end

  assign poolFull = ~|dead_mask;
  assign accept   = spawnSCEN && (spawnType != 2'b00) && canSpawn && (cooldown_q == '0) &&
                    !poolFull;

  // Isolate the lowest set bit: lowest-index DEAD slot wins the spawn.
  assign first_dead = dead_mask & (~dead_mask + NUM_UNITS'(1));
  assign spawn_sel  = accept ? first_dead : '0;

  always_comb begin
    attack_sum = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (attack[i]) attack_sum = attack_sum + SumW'(slot_power[i]);
    end
  end

  assign attack_sat = (attack_sum > SumW'({HP_W{1'b1}})) ? '1 : attack_sum[HP_W-1:0];

  always_comb begin
    front = '1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (aliveMask[i] && (slot_pos[i] < front)) front = slot_pos[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cooldown_q     <= '0;
      spawn_accept_q <= 1'b0;
      damage_q       <= '0;
    end else begin
      spawn_accept_q <= accept;
      if (accept)                  cooldown_q <= CdW'(COOLDOWN);
      else if (cooldown_q != '0)   cooldown_q <= cooldown_q - CdW'(1);
      if (moveSCEN)                damage_q   <= attack_sat;
    end
  end

  assign spawnAccept = spawn_accept_q;
  assign damageOut   = damage_q;
  assign frontPos    = front;
  assign frontValid  = |aliveMask;

endmodule

// File: tb/tb_unit_pool.sv
// Directed bench for unit_pool at default parameters: spawn, cooldown,
// damage/death, movement/attack and reset-abort scenarios.
module tb_unit_pool;

  localparam int unsigned NUM_UNITS  = 4;
  localparam int unsigned POS_W      = 9;
  localparam int unsigned HP_W       = 8;
  localparam int unsigned COOLDOWN   = 15;
  localparam int unsigned DEATH_HOLD = 10;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        spawnSCEN;
  logic [1:0]                  spawnType;
  logic                        canSpawn;
  logic                        moveSCEN;
  logic                        damageSCEN;
  logic [1:0]                  damageIdx;
  logic [HP_W-1:0]             damageIn;
  logic [POS_W-1:0]            enemyFront;
  logic                        spawnAccept;
  logic                        poolFull;
  logic [NUM_UNITS*POS_W-1:0]  positionFlat;
  logic [NUM_UNITS*2-1:0]      unitTypeFlat;
  logic [NUM_UNITS-1:0]        aliveMask;
  logic [HP_W-1:0]             damageOut;
  logic [POS_W-1:0]            frontPos;
  logic                        frontValid;

  int checks = 0;
  int errors = 0;

  unit_pool #(
    .NUM_UNITS  (NUM_UNITS),
    .POS_W      (POS_W),
    .HP_W       (HP_W),
    .COOLDOWN   (COOLDOWN),
    .DEATH_HOLD (DEATH_HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spawnSCEN    (spawnSCEN),
    .spawnType    (spawnType),
    .canSpawn     (canSpawn),
    .moveSCEN     (moveSCEN),
    .damageSCEN   (damageSCEN),
    .damageIdx    (damageIdx),
    .damageIn     (damageIn),
    .enemyFront   (enemyFront),
    .spawnAccept  (spawnAccept),
    .poolFull     (poolFull),
    .positionFlat (positionFlat),
    .unitTypeFlat (unitTypeFlat),
    .aliveMask    (aliveMask),
    .damageOut    (damageOut),
    .frontPos     (frontPos),
    .frontValid   (frontValid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spawn_req(input logic [1:0] t, input logic en);
    spawnSCEN = 1'b1;
    spawnType = t;
    canSpawn  = en;
    tick(1);
    spawnSCEN = 1'b0;
    spawnType = 2'd0;
    canSpawn  = 1'b1;
  endtask

  task automatic move_tick();
    moveSCEN = 1'b1;
    tick(1);
    moveSCEN = 1'b0;
  endtask

  task automatic damage(input logic [1:0] idx, input logic [HP_W-1:0] amt);
    damageSCEN = 1'b1;
    damageIdx  = idx;
    damageIn   = amt;
    tick(1);
    damageSCEN = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic logic [POS_W-1:0] pos_of(input int i);
    return positionFlat[i*POS_W +: POS_W];
  endfunction

  function automatic logic [1:0] type_of(input int i);
    return unitTypeFlat[i*2 +: 2];
  endfunction

  initial begin
    reset = 1'b1; spawnSCEN = 1'b0; spawnType = 2'd0; canSpawn = 1'b1;
    moveSCEN = 1'b0; damageSCEN = 1'b0; damageIdx = 2'd0; damageIn = '0;
    enemyFront = 9'd509;
    tick(2);
    reset = 1'b0;

    check_eq("rst_alive",   64'(aliveMask), 64'h0);
    check_eq("rst_full",    64'(poolFull), 64'h0);
    check_eq("rst_fvalid",  64'(frontValid), 64'h0);
    check_eq("rst_fpos",    64'(frontPos), 64'h1FF);
    check_eq("rst_dmg",     64'(damageOut), 64'h0);
    check_eq("rst_acc",     64'(spawnAccept), 64'h0);
    check_eq("rst_pos",     64'(positionFlat), 64'hF_FFFF_FFFF);

    // First spawn: accept pulse, one DEPLOY cycle, then ALIVE type 2 at 511.
    spawn_req(2'd2, 1'b1);
    check_eq("sp1_acc",     64'(spawnAccept), 64'h1);
    check_eq("sp1_deploy",  64'(aliveMask), 64'h0);
    tick(1);
    check_eq("sp1_acc_off", 64'(spawnAccept), 64'h0);
    check_eq("sp1_alive",   64'(aliveMask), 64'h1);
    check_eq("sp1_type",    64'(type_of(0)), 64'h2);
    check_eq("sp1_pos",     64'(pos_of(0)), 64'd511);
    check_eq("sp1_front",   64'(frontPos), 64'd511);
    check_eq("sp1_fvalid",  64'(frontValid), 64'h1);
    spawn_req(2'd1, 1'b1);
    check_eq("cd_drop",     64'(spawnAccept), 64'h0);

    // Reset mid-cooldown, then reset mid-DEPLOY.
    pulse_reset();
    check_eq("rst_cd_alive", 64'(aliveMask), 64'h0);
    spawn_req(2'd1, 1'b1);
    check_eq("rst_cd_acc",  64'(spawnAccept), 64'h1);
    pulse_reset();
    check_eq("rst_dep_acc", 64'(spawnAccept), 64'h0);
    tick(1);
    check_eq("rst_dep_alive", 64'(aliveMask), 64'h0);

    // Slot 0 type 1, then walk it to enemyFront = 509 and attack.
    spawn_req(2'd1, 1'b1);
    check_eq("sp2_acc",     64'(spawnAccept), 64'h1);
    tick(1);
    check_eq("sp2_type",    64'(type_of(0)), 64'h1);
    move_tick();
    check_eq("mv1_pos",     64'(pos_of(0)), 64'd510);
    check_eq("mv1_dmg",     64'(damageOut), 64'd0);
    check_eq("mv1_front",   64'(frontPos), 64'd510);
    move_tick();
    check_eq("mv2_pos",     64'(pos_of(0)), 64'd509);
    move_tick();
    check_eq("mv3_dmg",     64'(damageOut), 64'd32);
    check_eq("mv3_pos",     64'(pos_of(0)), 64'd509);
    tick(1);
    check_eq("dmg_hold",    64'(damageOut), 64'd32);

    // Cooldown boundary: 14 edges after accept still blocked, 15 open.
    tick(9);
    spawn_req(2'd3, 1'b1);
    check_eq("cd_edge_drop", 64'(spawnAccept), 64'h0);
    spawn_req(2'd0, 1'b1);
    check_eq("type0_drop",  64'(spawnAccept), 64'h0);
    spawn_req(2'd3, 1'b0);
    check_eq("cansp_drop",  64'(spawnAccept), 64'h0);
    spawn_req(2'd3, 1'b1);
    check_eq("sp_s1_acc",   64'(spawnAccept), 64'h1);
    tick(COOLDOWN);
    spawn_req(2'd3, 1'b1);
    check_eq("sp_s2_acc",   64'(spawnAccept), 64'h1);
    tick(COOLDOWN);
    spawn_req(2'd3, 1'b1);
    check_eq("sp_s3_acc",   64'(spawnAccept), 64'h1);
    check_eq("full_deploy", 64'(poolFull), 64'h1);
    tick(1);
    check_eq("full_alive",  64'(aliveMask), 64'hF);
    check_eq("full_types",  64'(unitTypeFlat), 64'hFD);
    check_eq("full_front",  64'(frontPos), 64'd509);
    tick(COOLDOWN - 1);
    spawn_req(2'd1, 1'b1);
    check_eq("full_drop",   64'(spawnAccept), 64'h0);

    // Everyone attacks: 32 + 3*128 saturates.
    enemyFront = 9'd511;
    move_tick();
    check_eq("sat_dmg",     64'(damageOut), 64'hFF);
    check_eq("sat_pos",     64'(positionFlat), 64'({9'd511, 9'd511, 9'd511, 9'd509}));

    // Slot 1: 255 - 200 = 55 survives, 100 >= 55 kills.
    damage(2'd1, 8'd200);
    check_eq("hit_alive",   64'(aliveMask), 64'hF);
    damage(2'd1, 8'd100);
    check_eq("kill_alive",  64'(aliveMask), 64'hD);
    check_eq("kill_types",  64'(unitTypeFlat), 64'hF1);
    check_eq("dying_full",  64'(poolFull), 64'h1);
    tick(DEATH_HOLD - 1);
    check_eq("dying_hold",  64'(poolFull), 64'h1);
    tick(1);
    check_eq("dead_free",   64'(poolFull), 64'h0);
    spawn_req(2'd1, 1'b1);
    check_eq("reuse_acc",   64'(spawnAccept), 64'h1);
    tick(1);
    check_eq("reuse_alive", 64'(aliveMask), 64'hF);
    check_eq("reuse_types", 64'(unitTypeFlat), 64'hF5);
    check_eq("reuse_pos",   64'(pos_of(1)), 64'd511);

    // Kill slot 2 on the tick edge: 32 + 32 + 128 = 192 (exact-health kill).
    moveSCEN   = 1'b1;
    damage(2'd2, 8'd255);
    moveSCEN   = 1'b0;
    check_eq("kmv_dmg",     64'(damageOut), 64'd192);
    check_eq("kmv_alive",   64'(aliveMask), 64'hB);
    tick(1);
    check_eq("kmv_hold",    64'(damageOut), 64'd192);

    // Reset mid-DYING clears everything.
    pulse_reset();
    check_eq("rst2_alive",  64'(aliveMask), 64'h0);
    check_eq("rst2_full",   64'(poolFull), 64'h0);
    check_eq("rst2_dmg",    64'(damageOut), 64'h0);
    check_eq("rst2_pos",    64'(positionFlat), 64'hF_FFFF_FFFF);
    check_eq("rst2_types",  64'(unitTypeFlat), 64'h0);
    check_eq("rst2_fvalid", 64'(frontValid), 64'h0);
    check_eq("rst2_fpos",   64'(frontPos), 64'h1FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unit_pool.md
UNIT_POOL -- requirements
Module: unit_pool

Interface
REQ-001 Parameter NUM_UNITS, default 4: number of unit slots, range 2..8.
REQ-002 Parameter POS_W, default 9: position width; spawn position = all ones.
REQ-003 Parameter HP_W, default 8: health, power and damage width.
REQ-004 Parameter COOLDOWN, default 15: cycles after an accepted spawn before the next spawn is accepted.
REQ-005 Parameter DEATH_HOLD, default 10: cycles a killed slot stays in DYING.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 spawnSCEN  in  1  single-cycle spawn request.
REQ-009 spawnType  in  2  requested unit type 1..3; 0 is ignored.
REQ-010 canSpawn  in  1  spawn enable from top level.
REQ-011 moveSCEN  in  1  single-cycle game-tick strobe: move or attack.
REQ-012 damageSCEN  in  1  single-cycle damage strobe.
REQ-013 damageIdx  in  clog2(NUM_UNITS)  target slot of damage.
REQ-014 damageIn  in  HP_W  damage amount.
REQ-015 enemyFront  in  POS_W  position of the frontmost enemy.
REQ-016 spawnAccept  out  1  one-cycle pulse: spawn accepted.
REQ-017 poolFull  out  1  no slot in DEAD.
REQ-018 positionFlat  out  NUM_UNITS*POS_W  slot i at bits [i*POS_W +: POS_W].
REQ-019 unitTypeFlat  out  NUM_UNITS*2  slot i type; 00 when not ALIVE.
REQ-020 aliveMask  out  NUM_UNITS  bit i = slot i ALIVE.
REQ-021 damageOut  out  HP_W  saturating sum of this tick's attack power.
REQ-022 frontPos / frontValid  out  POS_W / 1  minimum position over ALIVE slots; frontPos all ones and frontValid 0 when none is ALIVE.

Function
REQ-023 Each slot SHALL implement states DEAD, DEPLOY, ALIVE and DYING.
REQ-024 DEAD -> DEPLOY on slot selection; DEPLOY -> ALIVE after exactly one cycle; ALIVE -> DYING on kill; DYING -> DEAD after DEATH_HOLD cycles.
REQ-025 A spawn SHALL be accepted when spawnSCEN=1, spawnType!=0, canSpawn=1, cooldown=0 and poolFull=0; otherwise it is dropped silently.
REQ-026 An accepted spawn SHALL go to the lowest-index DEAD slot, which loads position all ones, health all ones, and power per type (1:32, 2:64, 3:128, scaled as the value << (HP_W-8)).
REQ-027 spawnAccept SHALL assert in the cycle after the request; the cooldown SHALL load COOLDOWN on the same edge and decrement to 0.
REQ-028 On damageSCEN for an ALIVE target, health SHALL reduce by damageIn; if health <= damageIn the slot goes to DYING with health 0 (no underflow).
REQ-029 Damage to a non-ALIVE slot SHALL be ignored.
REQ-030 On moveSCEN, each ALIVE slot with position > enemyFront SHALL decrement its position by 1; otherwise it adds its power to the attack sum.
REQ-031 damageOut SHALL register the attack sum on the moveSCEN edge, saturate at all ones, and hold until the next moveSCEN.
REQ-032 If a slot is killed in the same cycle as moveSCEN, it SHALL neither move nor attack.
REQ-033 A slot entering DYING SHALL NOT be spawnable until it reaches DEAD.
REQ-034 Position SHALL never wrap below 0; a slot at 0 attacks.
REQ-035 frontPos, frontValid, aliveMask and poolFull SHALL be combinational from slot registers; ties on frontPos go to any slot (value only).

Reset
REQ-036 While reset=1, on each clk edge: all slots -> DEAD, positions all ones, health and power 0, cooldown 0, damageOut 0, spawnAccept 0.
REQ-037 A reset asserted mid-DEPLOY, mid-DYING or mid-cooldown SHALL abort it with no residual pulse.

Structure
REQ-038 Package unit_pkg SHALL hold the slot-state encoding, the unit-type codes and the type-to-power table.
REQ-039 One sub-module, unit_slot, SHALL be instantiated NUM_UNITS times; unit_pool holds spawn arbitration, cooldown, attack summation and frontPos reduction.

Verification
REQ-040 After reset, spawnType=2, canSpawn=1 -> spawnAccept one cycle later, slot 0 ALIVE type 10 at position 511 after DEPLOY.
REQ-041 Four spawns spaced COOLDOWN+1 cycles apart -> slots 0..3 fill and poolFull=1; fifth request gives no spawnAccept; a request inside the cooldown is dropped.
REQ-042 Slot 1 health 255 with damageIn 200 then 100 -> health 55, then DYING; DEAD after 10 cycles; next spawn reuses slot 1.
REQ-043 enemyFront=509 with slot 0 at 511 -> two moveSCEN move it to 509; third gives damageOut=32 (type 1).
REQ-044 Three type-3 units attacking, HP_W=8 -> damageOut=255 (saturated).
REQ-045 Kill damage and moveSCEN in the same cycle on an attacking slot -> its power is excluded from damageOut and aliveMask bit clears.
